// File: rtl/m_lsu.sv
// m_lsu: load/store unit with a private word-organised data memory.
//   RV32I LB/LH/LW/LBU/LHU/SB/SH/SW, little-endian byte lanes, sign/zero extension.
//   Request and response each use a valid/ready handshake. The response appears
//   LAT cycles after accept and is held until the consumer takes it.
//   Bad funct3, misaligned and out-of-range requests are answered with err=1
//   and leave memory untouched.
// Ports:
//   w_clk, w_rst_n                          clock, async active-low reset
//   w_req_valid/ready/we/funct3/addr/wdata  request channel
//   w_rsp_valid/ready/rdata/err             response channel
module m_lsu #(
  parameter int DEPTH = 64,
  parameter int LAT   = 1
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        w_req_valid,
  output logic        w_req_ready,
  input  logic        w_req_we,
  input  logic [2:0]  w_req_funct3,
  input  logic [31:0] w_req_addr,
  input  logic [31:0] w_req_wdata,
  output logic        w_rsp_valid,
  input  logic        w_rsp_ready,
  output logic [31:0] w_rsp_rdata,
  output logic        w_rsp_err
);
  localparam int NUM_LANES = 4;
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t     state;
  logic [3:0] cnt;

  logic [NUM_LANES-1:0][7:0] mem [DEPTH];

  logic [AW-1:0]             idx;
  logic [1:0]                lane;
  logic                      f3_bad, mis, oor, err_c, accept, wr_en;
  logic [NUM_LANES-1:0]      be;
  logic [NUM_LANES-1:0][7:0] wbytes;
  logic [31:0]               word, ld_val;
  logic [7:0]                ld_b;
  logic [15:0]               ld_h;

  assign w_req_ready = (state == IDLE);
  assign accept      = w_req_valid & w_req_ready;
  assign idx         = w_req_addr[AW+1:2];
  assign lane        = w_req_addr[1:0];

  // Error priority: funct3 first, then alignment, then range.
  always_comb begin
    f3_bad = 1'b0;
    case (w_req_funct3)
      3'b000, 3'b001, 3'b010: f3_bad = 1'b0;
      3'b100, 3'b101:         f3_bad = w_req_we;  // no unsigned stores
      default:                f3_bad = 1'b1;
    endcase
    mis   = (w_req_funct3[1:0] == 2'b01) ? lane[0]
          : (w_req_funct3[1:0] == 2'b10) ? (lane != 2'b00) : 1'b0;
    oor   = (w_req_addr[31:2] >= 30'(DEPTH));
    err_c = f3_bad | mis | oor;
  end

  // Store lane enables and replicated data so each lane just picks its byte.
  always_comb begin
    be     = '0;
    wbytes = w_req_wdata;
    case (w_req_funct3[1:0])
      2'b00: begin
        be            = 4'b0001 << lane;
        wbytes        = {4{w_req_wdata[7:0]}};
      end
      2'b01: begin
        be            = lane[1] ? 4'b1100 : 4'b0011;
        wbytes        = {2{w_req_wdata[15:0]}};
      end
      default: be     = 4'b1111;
    endcase
  end

  assign wr_en = accept & w_req_we & ~err_c;

  always_ff @(posedge w_clk) begin
    if (wr_en)
      for (int l = 0; l < NUM_LANES; l++)
        if (be[l]) mem[idx][l] <= wbytes[l];
  end

  // Load extraction from the word as it stands at the accept edge.
  always_comb begin
    word   = oor ? 32'h0 : mem[idx];
    ld_b   = word[8*lane +: 8];
    ld_h   = lane[1] ? word[31:16] : word[15:0];
    ld_val = '0;
    case (w_req_funct3)
      3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b010:  ld_val = word;
      3'b100:  ld_val = {24'h0, ld_b};
      3'b101:  ld_val = {16'h0, ld_h};
      default: ld_val = '0;
    endcase
  end

  // RESP spends one cycle with valid low before raising it, so valid rises
  // exactly LAT edges after accept for every LAT.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      w_rsp_valid <= 1'b0;
      w_rsp_rdata <= '0;
      w_rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          w_rsp_err   <= err_c;
          w_rsp_rdata <= (err_c | w_req_we) ? 32'h0 : ld_val;
          if (LAT == 1) state <= RESP;
          else begin
            state <= WAIT;
            cnt   <= 4'(LAT - 1);
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          if (!w_rsp_valid) w_rsp_valid <= 1'b1;
          else if (w_rsp_ready) begin
            w_rsp_valid <= 1'b0;
            w_rsp_rdata <= '0;
            w_rsp_err   <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m_lsu.sv
// tb_m_lsu: checks m_lsu with LAT=1 (instance 0) and LAT=3 (instance 1).
module tb_m_lsu;
  logic        w_clk;
  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_f3    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int total = 0;
  int bad   = 0;

  logic [7:0] mb [256];  // byte-addressed reference memory for instance 0

  m_lsu #(.DEPTH(64), .LAT(1)) u_l1 (
    .w_clk(w_clk), .w_rst_n(rst_n[0]),
    .w_req_valid(req_valid[0]), .w_req_ready(req_ready[0]), .w_req_we(req_we[0]),
    .w_req_funct3(req_f3[0]), .w_req_addr(req_addr[0]), .w_req_wdata(req_wdata[0]),
    .w_rsp_valid(rsp_valid[0]), .w_rsp_ready(rsp_ready[0]),
    .w_rsp_rdata(rsp_rdata[0]), .w_rsp_err(rsp_err[0]));

  m_lsu #(.DEPTH(64), .LAT(3)) u_l3 (
    .w_clk(w_clk), .w_rst_n(rst_n[1]),
    .w_req_valid(req_valid[1]), .w_req_ready(req_ready[1]), .w_req_we(req_we[1]),
    .w_req_funct3(req_f3[1]), .w_req_addr(req_addr[1]), .w_req_wdata(req_wdata[1]),
    .w_rsp_valid(rsp_valid[1]), .w_rsp_ready(rsp_ready[1]),
    .w_rsp_rdata(rsp_rdata[1]), .w_rsp_err(rsp_err[1]));

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout waiting on DUT", nm);
  endtask

  // One full transaction: present at negedge, accept on a posedge, then wait
  // for the response and take it. lat counts edges from accept to valid.
  task automatic xact(input int d, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge w_clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_f3[d] = f3;
    req_addr[d]  = a;    req_wdata[d] = wd;
    n = 0;
    while (!req_ready[d] && n < 50) begin @(negedge w_clk); n++; end
    if (n >= 50) timeout("req_ready");
    @(posedge w_clk); #1;
    req_valid[d] = 1'b0;
    lat = 0;
    while (!rsp_valid[d] && lat < 40) begin @(posedge w_clk); #1; lat++; end
    if (lat >= 40) timeout("rsp_valid");
    rd = rsp_rdata[d]; er = rsp_err[d];
    rsp_ready[d] = 1'b1;
    @(posedge w_clk); #1;
    rsp_ready[d] = 1'b0;
  endtask

  // Reference: byte-addressed memory, sizes and extension from plain arithmetic.
  function automatic void ref_op(input logic we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output logic [31:0] rd, output logic er);
    int sz;
    logic [31:0] v;
    rd = '0; er = 1'b0;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (we && f3[2])) er = 1'b1;
    else if ((a % sz) != 0) er = 1'b1;
    else if ((a >> 2) >= 64) er = 1'b1;
    if (er) return;
    if (we) begin
      for (int i = 0; i < sz; i++) mb[int'(a) + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < sz; i++) v = v | (32'(mb[int'(a) + i]) << (8*i));
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
      rd = v;
    end
  endfunction

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [24];

  initial begin
    logic [31:0] rd, erd, a, wd;
    logic        er, eer, we;
    logic [2:0]  f3;
    int          lat, seen;

    tbl[0]  = '{1'b1, 3'b010, 32'd8,   32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 3'b010, 32'd8,   32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 3'b000, 32'd9,   32'h0,        32'hFFFFFFBE, 1'b0};
    tbl[3]  = '{1'b0, 3'b100, 32'd9,   32'h0,        32'h000000BE, 1'b0};
    tbl[4]  = '{1'b0, 3'b001, 32'd10,  32'h0,        32'hFFFFDEAD, 1'b0};
    tbl[5]  = '{1'b0, 3'b101, 32'd10,  32'h0,        32'h0000DEAD, 1'b0};
    tbl[6]  = '{1'b1, 3'b000, 32'd11,  32'hAAAAAA12, 32'h0,        1'b0};
    tbl[7]  = '{1'b1, 3'b001, 32'd8,   32'h55557777, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 3'b010, 32'd8,   32'h0,        32'h12AD7777, 1'b0};
    tbl[9]  = '{1'b1, 3'b010, 32'd4,   32'hCAFEF00D, 32'h0,        1'b0};
    tbl[10] = '{1'b1, 3'b010, 32'd0,   32'h01020304, 32'h0,        1'b0};
    tbl[11] = '{1'b0, 3'b010, 32'd6,   32'h0,        32'h0,        1'b1};
    tbl[12] = '{1'b1, 3'b001, 32'd5,   32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[13] = '{1'b0, 3'b011, 32'd4,   32'h0,        32'h0,        1'b1};
    tbl[14] = '{1'b1, 3'b010, 32'd256, 32'hBAD0BAD0, 32'h0,        1'b1};
    tbl[15] = '{1'b1, 3'b100, 32'd4,   32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[16] = '{1'b0, 3'b010, 32'd4,   32'h0,        32'hCAFEF00D, 1'b0};
    tbl[17] = '{1'b0, 3'b010, 32'd0,   32'h0,        32'h01020304, 1'b0};
    tbl[18] = '{1'b1, 3'b010, 32'd252, 32'h80000001, 32'h0,        1'b0};
    tbl[19] = '{1'b0, 3'b000, 32'd252, 32'h0,        32'h00000001, 1'b0};
    tbl[20] = '{1'b0, 3'b001, 32'd254, 32'h0,        32'hFFFF8000, 1'b0};
    tbl[21] = '{1'b0, 3'b101, 32'd7,   32'h0,        32'h0,        1'b1};
    tbl[22] = '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,   32'h0,        1'b1};
    tbl[23] = '{1'b1, 3'b110, 32'd16,  32'h0,        32'h0,        1'b1};

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_f3[d] = '0;
      req_addr[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b0;
    end

    // Asynchronous reset, checked before any clock edge.
    #2;
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_ready", d), 32'(req_ready[d]), 32'd1);
      chk($sformatf("rst%0d_valid", d), 32'(rsp_valid[d]), 32'd0);
      chk($sformatf("rst%0d_rdata", d), rsp_rdata[d], 32'd0);
      chk($sformatf("rst%0d_err", d),   32'(rsp_err[d]), 32'd0);
    end
    repeat (2) @(negedge w_clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // Directed vectors on the LAT=1 instance.
    for (int i = 0; i < 24; i++) begin
      xact(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, er, lat);
      chk($sformatf("row%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("row%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      chk($sformatf("row%0d_lat", i), 32'(lat), 32'd1);
    end

    // LAT=3: latency, then hold the response under back-pressure.
    xact(1, 1'b1, 3'b010, 32'd12, 32'h11223344, rd, er, lat);
    chk("l3_store_lat", 32'(lat), 32'd3);
    @(negedge w_clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_f3[1] = 3'b010; req_addr[1] = 32'd12;
    @(posedge w_clk); #1;
    req_valid[1] = 1'b0;
    chk("l3_valid_e0", 32'(rsp_valid[1]), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge w_clk); #1;
      chk($sformatf("l3_valid_e%0d", k), 32'(rsp_valid[1]), (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("l3_ready_e%0d", k), 32'(req_ready[1]), 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge w_clk); #1;
      chk($sformatf("hold%0d_valid", k), 32'(rsp_valid[1]), 32'd1);
      chk($sformatf("hold%0d_rdata", k), rsp_rdata[1], 32'h11223344);
      chk($sformatf("hold%0d_err", k),   32'(rsp_err[1]), 32'd0);
      chk($sformatf("hold%0d_ready", k), 32'(req_ready[1]), 32'd0);
    end
    rsp_ready[1] = 1'b1;
    @(posedge w_clk); #1;
    rsp_ready[1] = 1'b0;
    chk("release_valid", 32'(rsp_valid[1]), 32'd0);
    chk("release_ready", 32'(req_ready[1]), 32'd1);

    // LAT=3: reset while in WAIT drops the response but keeps the store.
    @(negedge w_clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_f3[1] = 3'b010;
    req_addr[1] = 32'd0; req_wdata[1] = 32'h00000055;
    @(posedge w_clk); #1;
    req_valid[1] = 1'b0;
    @(posedge w_clk); #5;
    rst_n[1] = 1'b0;
    #1;
    chk("wrst_valid", 32'(rsp_valid[1]), 32'd0);
    chk("wrst_ready", 32'(req_ready[1]), 32'd1);
    @(negedge w_clk);
    rst_n[1] = 1'b1;
    seen = 0;
    repeat (6) begin @(posedge w_clk); #1; if (rsp_valid[1]) seen++; end
    chk("wrst_no_rsp", 32'(seen), 32'd0);
    xact(1, 1'b0, 3'b010, 32'd0, 32'h0, rd, er, lat);
    chk("wrst_lw_rdata", rd, 32'h00000055);
    chk("wrst_lw_lat", 32'(lat), 32'd3);

    // LAT=1: reset while a response is presented, mid-cycle.
    @(negedge w_clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_f3[0] = 3'b010; req_addr[0] = 32'd8;
    @(posedge w_clk); #1;
    req_valid[0] = 1'b0;
    @(posedge w_clk); #1;
    chk("rrst_pre_valid", 32'(rsp_valid[0]), 32'd1);
    chk("rrst_pre_rdata", rsp_rdata[0], 32'h12AD7777);
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk("rrst_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rrst_rdata", rsp_rdata[0], 32'd0);
    chk("rrst_ready", 32'(req_ready[0]), 32'd1);
    @(negedge w_clk);
    rst_n[0] = 1'b1;
    seen = 0;
    repeat (4) begin @(posedge w_clk); #1; if (rsp_valid[0]) seen++; end
    chk("rrst_no_rsp", 32'(seen), 32'd0);

    // Randomised traffic against the byte-level model: define every word first.
    for (int w = 0; w < 64; w++) begin
      wd = $urandom;
      ref_op(1'b1, 3'b010, 32'(4*w), wd, erd, eer);
      xact(0, 1'b1, 3'b010, 32'(4*w), wd, rd, er, lat);
    end
    for (int i = 0; i < 250; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        8:       a = 32'($urandom_range(256, 400));
        9:       a = $urandom;
        default: a = 32'($urandom_range(0, 255));
      endcase
      wd = $urandom;
      ref_op(we, f3, a, wd, erd, eer);
      xact(0, we, f3, a, wd, rd, er, lat);
      chk($sformatf("rnd%0d_rdata(we=%0d f3=%0d a=%h)", i, we, f3, a), rd, erd);
      chk($sformatf("rnd%0d_err", i), 32'(er), 32'(eer));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
